fc_layer_stream: RTL and testbench

Parametrised fully-connected CNN layer engine for the classifier back end. It accepts one signed activation per handshake and multiply-accumulates it against `LANES` weights per cycle. It sweeps `N_OUT/LANES` accumulator groups per input, then adds a per-neuron bias and an optional ReLU. The `N_OUT` results stream out `LANES` at a time under valid/ready backpressure. It replaces the fixed 16-lane/64-neuron/100-input dense layer and adds input/output handshakes, synchronous abort and parametrised geometry.

---
 rtl/fc_layer_stream.sv | 213 +++++++++++++++++++++
 tb/tb_fc_layer_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: one activation per handshake, LANES MACs per cycle over
// N_OUT/LANES accumulator groups, then bias add and result streaming. FC_RELU_EN enables output ReLU.
module fc_layer_stream #(
  parameter int N_IN   = 100,
  parameter int N_OUT  = 64,
  parameter int LANES  = 16,
  parameter int DIN_W  = 18,
  parameter int WGT_W  = 9,
  parameter int BIAS_W = 9,
  parameter int ACC_W  = 36,
  localparam int GROUPS = N_OUT / LANES,
  localparam int WA_W   = (N_IN * GROUPS > 1) ? $clog2(N_IN * GROUPS) : 1,
  localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    strt,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIN_W-1:0]        din,
  output logic [WA_W-1:0]         wgt_addr,
  input  logic [LANES*WGT_W-1:0]  wgt_data,
  output logic [BA_W-1:0]         bias_addr,
  input  logic [LANES*BIAS_W-1:0] bias_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int GW = $clog2(GROUPS + 1);
  localparam int CW = $clog2(N_IN + 1);
  localparam int PW = DIN_W + WGT_W;

  if (N_OUT % LANES != 0) begin : g_geom_check
    $error("fc_layer_stream: N_OUT must be a multiple of LANES");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    MAC     = 3'd2,
    BIAS    = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t                   state_r, state_nx;
  logic [CW-1:0]            in_cnt_r;
  logic [GW-1:0]            grp_r;
  logic signed [DIN_W-1:0]  din_r;
  logic [ACC_W-1:0]         acc_r [GROUPS][LANES];
  logic                     in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
  logic [WA_W-1:0]          wgt_addr_r;
  logic [BA_W-1:0]          bias_addr_r;
  logic [LANES*ACC_W-1:0]   out_data_r;

  logic                     hs_in_s, hs_out_s, last_grp_s, done_nx_s;
  logic [BA_W-1:0]          acc_idx_s, rd_idx_s;
  logic signed [PW-1:0]     prod_s [LANES];
  logic [ACC_W-1:0]         mac_s  [LANES];
  logic [ACC_W-1:0]         bsum_s [LANES];
  logic [LANES*ACC_W-1:0]   out_nx_s;

  function automatic logic [ACC_W-1:0] relu_f(input logic [ACC_W-1:0] v);
`ifdef FC_RELU_EN
    return v[ACC_W-1] ? {ACC_W{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign wgt_addr  = wgt_addr_r;
  assign bias_addr = bias_addr_r;
  assign out_data  = out_data_r;

  // Handshake and group decode shared by FSM and datapath
  always_comb begin
    hs_in_s    = in_valid && in_ready_r;
    hs_out_s   = out_valid_r && out_ready;
    last_grp_s = (grp_r == GW'(GROUPS - 1));
    done_nx_s  = (state_r == OUT) && hs_out_s && last_grp_s && !clr;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next-state logic; abort wins over every other event
  always_comb begin
    state_nx = state_r;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (strt) state_nx = WAIT_IN; else state_nx = IDLE;
        WAIT_IN: if (hs_in_s) state_nx = MAC; else state_nx = WAIT_IN;
        MAC: begin
          if (grp_r == GW'(GROUPS)) state_nx = (in_cnt_r == CW'(N_IN - 1)) ? BIAS : WAIT_IN;
          else                      state_nx = MAC;
        end
        BIAS:    state_nx = OUT;
        OUT: begin
          if (hs_out_s) state_nx = last_grp_s ? IDLE : BIAS;
          else          state_nx = OUT;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // MAC lanes, bias add and output function
  always_comb begin
    acc_idx_s = BA_W'(grp_r - GW'(1));
    rd_idx_s  = BA_W'(grp_r);
    out_nx_s  = {(LANES*ACC_W){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = PW'($signed(din_r)) * PW'($signed(wgt_data[i*WGT_W +: WGT_W]));
      mac_s[i]  = ((in_cnt_r == {CW{1'b0}}) ? {ACC_W{1'b0}} : acc_r[acc_idx_s][i])
                  + ACC_W'(prod_s[i]);
      bsum_s[i] = acc_r[rd_idx_s][i] + ACC_W'($signed(bias_data[i*BIAS_W +: BIAS_W]));
      out_nx_s[i*ACC_W +: ACC_W] = relu_f(bsum_s[i]);
    end
  end

  // Accumulators: MAC cycle k+1 folds in the weights fetched for group k
  always_ff @(posedge clk) begin
    if (rst_n && !clr && state_r == MAC && grp_r != {GW{1'b0}}) begin
      for (int i = 0; i < LANES; i++) acc_r[acc_idx_s][i] <= mac_s[i];
    end
  end

  // Counters, ROM addresses and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      in_cnt_r    <= {CW{1'b0}};
      grp_r       <= {GW{1'b0}};
      wgt_addr_r  <= {WA_W{1'b0}};
      bias_addr_r <= {BA_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      if (!rst_n) begin
        din_r      <= {DIN_W{1'b0}};
        out_data_r <= {(LANES*ACC_W){1'b0}};
      end
    end else begin
      in_ready_r <= (state_nx == WAIT_IN);
      // busy stays up through the done pulse so it falls the cycle after
      busy_r     <= (state_nx != IDLE) || done_nx_s;
      done_r     <= done_nx_s;
      case (state_r)
        IDLE: begin
          if (strt) begin
            in_cnt_r   <= {CW{1'b0}};
            grp_r      <= {GW{1'b0}};
            wgt_addr_r <= {WA_W{1'b0}};
          end
        end
        WAIT_IN: begin
          if (hs_in_s) begin
            din_r <= $signed(din);
            grp_r <= {GW{1'b0}};
          end
        end
        MAC: begin
          if (grp_r < GW'(GROUPS)) wgt_addr_r <= wgt_addr_r + WA_W'(1);
          if (grp_r == GW'(GROUPS)) begin
            in_cnt_r    <= in_cnt_r + CW'(1);
            grp_r       <= {GW{1'b0}};
            bias_addr_r <= {BA_W{1'b0}};
          end else begin
            grp_r <= grp_r + GW'(1);
          end
        end
        BIAS: begin
          out_valid_r <= 1'b0;
        end
        OUT: begin
          if (!out_valid_r) begin
            out_data_r  <= out_nx_s;
            out_last_r  <= last_grp_s;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (last_grp_s) begin
              grp_r <= {GW{1'b0}};
            end else begin
              grp_r       <= grp_r + GW'(1);
              bias_addr_r <= BA_W'(grp_r + GW'(1));
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Randomized self-checking bench for fc_layer_stream (N_IN=3, N_OUT=4, LANES=2) against a
// plain-arithmetic dot-product model; a second instance with ACC_W=16 checks wraparound.
module tb_fc_layer_stream;
  localparam int N_IN = 3, N_OUT = 4, LANES = 2, G = N_OUT / LANES;
  localparam int DIN_W = 18, WGT_W = 9, BIAS_W = 9, ACC_W = 36, ACC16 = 16;

  logic clk = 1'b0, rst_n, strt, clr, in_valid, out_ready;
  logic [DIN_W-1:0] din;
  logic [LANES*WGT_W-1:0] wgt_data;
  logic [LANES*BIAS_W-1:0] bias_data;
  logic in_ready, out_valid, out_last, busy, done;
  logic [2:0] wgt_addr;
  logic [0:0] bias_addr;
  logic [LANES*ACC_W-1:0] out_data;
  logic in_ready16, out_valid16, out_last16, busy16, done16;
  logic [2:0] wgt_addr16;
  logic [0:0] bias_addr16;
  logic [LANES*ACC16-1:0] out_data16;

  int din_v [N_IN];
  int w_v [N_IN][N_OUT];
  int b_v [N_OUT];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  fc_layer_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .DIN_W(DIN_W), .WGT_W(WGT_W),
                    .BIAS_W(BIAS_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .wgt_addr(wgt_addr), .wgt_data(wgt_data), .bias_addr(bias_addr),
    .bias_data(bias_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  fc_layer_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .DIN_W(DIN_W), .WGT_W(WGT_W),
                    .BIAS_W(BIAS_W), .ACC_W(ACC16)) dut16 (
    .clk(clk), .rst_n(rst_n), .strt(strt), .clr(clr), .in_valid(in_valid), .in_ready(in_ready16),
    .din(din), .wgt_addr(wgt_addr16), .wgt_data(wgt_data), .bias_addr(bias_addr16),
    .bias_data(bias_data), .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_last(out_last16), .busy(busy16), .done(done16));

  // Weight and bias ROMs with one-cycle read latency
  always @(posedge clk) begin
    int a, r, c;
    a = int'(wgt_addr);
    r = (a < N_IN * G) ? a / G : 0;
    c = a % G;
    for (int i = 0; i < LANES; i++) begin
      wgt_data[i*WGT_W +: WGT_W]   <= WGT_W'(w_v[r][c*LANES + i]);
      bias_data[i*BIAS_W +: BIAS_W] <= BIAS_W'(b_v[int'(bias_addr)*LANES + i]);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expect_lane(input int j, input int accw);
    longint s;
    logic [63:0] m;
    s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'(din_v[k]) * longint'(w_v[k][j]);
    s += longint'(b_v[j]);
    m = 64'(s) & ((64'd1 << accw) - 64'd1);
`ifdef FC_RELU_EN
    if (m[accw-1]) m = 64'd0;
`endif
    return m;
  endfunction

  task automatic load(input int d0, input int d1, input int d2, input int w, input int b);
    din_v[0] = d0; din_v[1] = d1; din_v[2] = d2;
    for (int k = 0; k < N_IN; k++) for (int j = 0; j < N_OUT; j++) w_v[k][j] = w;
    for (int j = 0; j < N_OUT; j++) b_v[j] = b;
  endtask

  task automatic load_random();
    for (int k = 0; k < N_IN; k++) begin
      din_v[k] = int'($urandom_range(0, 262143)) - 131072;
      for (int j = 0; j < N_OUT; j++) w_v[k][j] = int'($urandom_range(0, 511)) - 256;
    end
    for (int j = 0; j < N_OUT; j++) b_v[j] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic run(input int gap_pct, input int stall_pct, input int hold0);
    int n_in, grp, cyc, last_in, last_out, held;
    bit seen, stalled, saved_last;
    logic [LANES*ACC_W-1:0] saved;
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    n_in = 0; grp = 0; cyc = 0; last_in = 0; last_out = 0; held = 0;
    seen = 1'b0; stalled = 1'b0; saved_last = 1'b0; saved = '0;
    while (grp < G && cyc < 2000) begin
      strt = ($urandom_range(0, 7) == 0);
      in_valid = (n_in < N_IN) ? ($urandom_range(0, 99) >= gap_pct) : 1'($urandom_range(0, 1));
      din = DIN_W'(din_v[(n_in < N_IN) ? n_in : 0]);
      if (out_valid && grp == 0 && held < hold0) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      check_eq("done_early", 64'(done), 64'd0);
      if (stalled) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_last", 64'(out_last), 64'(saved_last));
        for (int i = 0; i < LANES; i++)
          check_eq("hold_data", 64'(out_data[i*ACC_W +: ACC_W]), 64'(saved[i*ACC_W +: ACC_W]));
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (grp == 0) check_eq("first_lat", 64'(cyc - last_in), 64'(G + 4));
        else          check_eq("grp_gap", 64'(cyc - last_out), 64'd3);
      end
      if (in_valid && in_ready) begin
        if (gap_pct == 0 && n_in > 0) check_eq("cadence", 64'(cyc - last_in), 64'(G + 2));
        n_in++;
        last_in = cyc;
      end
      stalled = out_valid && !out_ready;
      saved = out_data;
      saved_last = out_last;
      if (out_valid && out_ready) begin
        for (int i = 0; i < LANES; i++) begin
          check_eq("lane36", 64'(out_data[i*ACC_W +: ACC_W]), expect_lane(grp*LANES + i, ACC_W));
          check_eq("lane16", 64'(out_data16[i*ACC16 +: ACC16]), expect_lane(grp*LANES + i, ACC16));
        end
        check_eq("last", 64'(out_last), 64'(grp == G - 1));
        check_eq("valid16", 64'(out_valid16), 64'd1);
        grp++;
        last_out = cyc;
        seen = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    strt = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("timeout", 64'(grp), 64'(G));
    check_eq("inputs", 64'(n_in), 64'(N_IN));
    check_eq("done_pulse", 64'({done, busy}), 64'd3);
    @(negedge clk);
    check_eq("done_end", 64'({done, busy, done16, busy16}), 64'd0);
  endtask

  task automatic abort_run();
    int hs, cyc;
    load_random();
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 100) begin
      in_valid = 1'b1;
      din = DIN_W'(din_v[hs]);
      if (in_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    check_eq("abort_to", 64'(hs), 64'd2);
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("abort_ctl", 64'({in_ready, out_valid, busy, done}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; strt = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    load(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 64'({in_ready, out_valid, out_last, busy, done}), 64'd0);
    check_eq("rst_addr", 64'({wgt_addr, bias_addr, wgt_addr16, bias_addr16}), 64'd0);
    for (int i = 0; i < LANES; i++) check_eq("rst_data", 64'(out_data[i*ACC_W +: ACC_W]), 64'd0);
    check_eq("rst_data16", 64'(out_data16), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ctl", 64'({in_ready, busy, in_ready16, busy16}), 64'd0);

    load(1, 2, 3, 1, 0);             run(0, 0, 0);
    load(-5, 0, 0, 1, 2);            run(0, 0, 0);
    load_random();                   run(0, 0, 5);
    abort_run();
    load(1, 2, 3, 1, 0);             run(0, 0, 0);
    load(32767, 32767, 32767, 255, 0); run(0, 0, 0);
    for (int t = 0; t < 8; t++) begin
      load_random();
      run(30, 40, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
